// File: rtl/vip_pattern_gen.sv
// vip_pattern_gen
// ---------------------------------------------------------------------------
// Video test source for the pclk/href/vsync/data pixel-stream protocol used by
// the vip_* filter chain. It generates full frame timing and one of four test
// patterns, so any vip_* stage can be driven without a camera.
//
// Optional feature macro: VIP_PATGEN_FRAMECNT_EN
//   defined   -> adds output frame_cnt[15:0] (frames completed since reset)
//                and mode 1 becomes a ramp that scrolls by one per frame.
//   undefined -> no frame_cnt port, mode 1 is a static horizontal ramp.
//
// Ports
//   pclk        in   pixel clock, all logic on the rising edge
//   rst         in   synchronous reset, active-high
//   enable      in   run request, acted on only at frame boundaries
//   mode[1:0]   in   0 colour bars, 1 h-ramp, 2 v-ramp, 3 checkerboard
//   out_href    out  active-pixel qualifier
//   out_vsync   out  frame sync, active-high
//   out_data    out  pixel value, 0 whenever out_href=0
//   frame_done  out  one-cycle pulse with the last pixel clock of a frame
//   frame_cnt   out  (VIP_PATGEN_FRAMECNT_EN only) completed-frame counter
//
// Pipeline: position counters -> stage 1 (position decode) -> output
// registers. out_vsync therefore rises two clocks after IDLE samples enable.
// ---------------------------------------------------------------------------
module vip_pattern_gen #(
    parameter int BITS        = 8,
    parameter int WIDTH       = 640,
    parameter int HEIGHT      = 480,
    parameter int H_BLANK     = 160,
    parameter int VSYNC_LINES = 2,
    parameter int V_BACK      = 33,
    parameter int V_FRONT     = 10
) (
    input  logic            pclk,
    input  logic            rst,
    input  logic            enable,
    input  logic [1:0]      mode,
    output logic            out_href,
    output logic            out_vsync,
    output logic [BITS-1:0] out_data,
    output logic            frame_done
`ifdef VIP_PATGEN_FRAMECNT_EN
    ,
    output logic [15:0]     frame_cnt
`endif
);

    localparam int HT    = WIDTH + H_BLANK;
    localparam int VT    = VSYNC_LINES + V_BACK + HEIGHT + V_FRONT;
    localparam int HW    = $clog2(HT + 1);
    localparam int VW    = $clog2(VT + 1);
    localparam int BAR_W = (WIDTH / 8 > 0) ? WIDTH / 8 : 1;
    localparam int BW    = $clog2(BAR_W + 1);
    // Decoded x/y are kept at least 6 bits wide so bit 5 (checker square) exists.
    localparam int DW    = (BITS > 6) ? BITS : 6;

    localparam logic [HW-1:0] H_LAST   = HW'(HT - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(WIDTH);
    localparam logic [VW-1:0] V_LAST   = VW'(VT - 1);
    localparam logic [VW-1:0] V_SYNC   = VW'(VSYNC_LINES);
    localparam logic [VW-1:0] V_ACT0   = VW'(VSYNC_LINES + V_BACK);
    localparam logic [VW-1:0] V_ACT1   = VW'(VSYNC_LINES + V_BACK + HEIGHT);
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);
    localparam logic [DW-1:0] Y_OFS    = DW'(VSYNC_LINES + V_BACK);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t          state_reg,   state_next;
    logic [HW-1:0]   hcnt_reg,    hcnt_next;
    logic [VW-1:0]   vcnt_reg,    vcnt_next;
    logic [BW-1:0]   bar_pos_reg, bar_pos_next;
    logic [2:0]      bar_k_reg,   bar_k_next;
    logic [1:0]      mode_reg;

    logic            h_last;
    logic            v_last;
    logic [DW-1:0]   y_diff;

    logic            s1_vsync_reg;
    logic            s1_href_reg;
    logic            s1_last_reg;
    logic [DW-1:0]   s1_x_reg;
    logic [DW-1:0]   s1_y_reg;
    logic [2:0]      s1_bar_reg;

    logic [BITS-1:0] bar_pix;
    logic [BITS-1:0] ramp_ofs;
    logic [BITS-1:0] pix_next;

    assign h_last = (hcnt_reg == H_LAST);
    assign v_last = (vcnt_reg == V_LAST);
    assign y_diff = DW'(vcnt_reg) - Y_OFS;

    // ------------------------------------------------------------------
    // Frame FSM and position counters
    // ------------------------------------------------------------------
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            hcnt_reg    <= '0;
            vcnt_reg    <= '0;
            bar_pos_reg <= '0;
            bar_k_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            hcnt_reg    <= hcnt_next;
            vcnt_reg    <= vcnt_next;
            bar_pos_reg <= bar_pos_next;
            bar_k_reg   <= bar_k_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        hcnt_next    = hcnt_reg;
        vcnt_next    = vcnt_reg;
        bar_pos_next = bar_pos_reg;
        bar_k_next   = bar_k_reg;
        case (state_reg)
            ST_IDLE: begin
                hcnt_next    = '0;
                vcnt_next    = '0;
                bar_pos_next = '0;
                bar_k_next   = '0;
                if (enable) begin
                    state_next = ST_RUN;
                end
            end
            default: begin
                if (h_last) begin
                    hcnt_next    = '0;
                    bar_pos_next = '0;
                    bar_k_next   = '0;
                    if (v_last) begin
                        // Frame boundary: the only place enable is honoured.
                        vcnt_next = '0;
                        if (!enable) begin
                            state_next = ST_IDLE;
                        end
                    end else begin
                        vcnt_next = vcnt_reg + 1'b1;
                    end
                end else begin
                    hcnt_next = hcnt_reg + 1'b1;
                    // Bar index tracks x/(WIDTH/8) without a divider; it
                    // saturates at 7 for any remainder pixels and the blanking.
                    if (bar_pos_reg == BAR_LAST) begin
                        bar_pos_next = '0;
                        if (bar_k_reg != 3'd7) begin
                            bar_k_next = bar_k_reg + 3'd1;
                        end
                    end else begin
                        bar_pos_next = bar_pos_reg + 1'b1;
                    end
                end
            end
        endcase
    end

    // Pattern select is captured while the counters sit at (0,0), so a
    // change mid-frame only shows up on the following frame.
    always_ff @(posedge pclk) begin
        if (rst) begin
            mode_reg <= 2'd0;
        end else if (state_reg == ST_RUN && hcnt_reg == '0 && vcnt_reg == '0) begin
            mode_reg <= mode;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: decode position into sync/active flags and x/y
    // ------------------------------------------------------------------
    always_ff @(posedge pclk) begin
        if (rst || state_reg != ST_RUN) begin
            s1_vsync_reg <= 1'b0;
            s1_href_reg  <= 1'b0;
            s1_last_reg  <= 1'b0;
            s1_x_reg     <= '0;
            s1_y_reg     <= '0;
            s1_bar_reg   <= '0;
        end else begin
            s1_vsync_reg <= (vcnt_reg < V_SYNC);
            s1_href_reg  <= (vcnt_reg >= V_ACT0) && (vcnt_reg < V_ACT1) &&
                            (hcnt_reg < H_ACT);
            s1_last_reg  <= h_last && v_last;
            s1_x_reg     <= DW'(hcnt_reg);
            s1_y_reg     <= y_diff;
            s1_bar_reg   <= bar_k_reg;
        end
    end

    // Colour bar value: the 3-bit bar index repeated MSB-first across BITS.
    genvar gi;
    generate
        for (gi = 0; gi < BITS; gi++) begin : g_bar_rep
            assign bar_pix[BITS-1-gi] = s1_bar_reg[2 - (gi % 3)];
        end
    endgenerate

`ifdef VIP_PATGEN_FRAMECNT_EN
    always_ff @(posedge pclk) begin
        if (rst) begin
            frame_cnt <= 16'd0;
        end else if (s1_last_reg) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

    assign ramp_ofs = BITS'(frame_cnt);
`else
    assign ramp_ofs = '0;
`endif

    always_comb begin
        pix_next = '0;
        if (s1_href_reg) begin
            case (mode_reg)
                2'd0:    pix_next = bar_pix;
                2'd1:    pix_next = s1_x_reg[BITS-1:0] + ramp_ofs;
                2'd2:    pix_next = s1_y_reg[BITS-1:0];
                default: pix_next = (s1_x_reg[5] ^ s1_y_reg[5]) ? '1 : '0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: output registers
    // ------------------------------------------------------------------
    always_ff @(posedge pclk) begin
        if (rst) begin
            out_href   <= 1'b0;
            out_vsync  <= 1'b0;
            out_data   <= '0;
            frame_done <= 1'b0;
        end else begin
            out_href   <= s1_href_reg;
            out_vsync  <= s1_vsync_reg;
            out_data   <= pix_next;
            frame_done <= s1_last_reg;
        end
    end

endmodule

// File: tb/tb_vip_pattern_gen.sv
// Self-checking bench for vip_pattern_gen. Two instances: u_dut (16x4 active,
// 20x7 total) for timing and most patterns, u_dut64 (64x4 active) for the
// checkerboard. Expected pixels come from a position-based model and are
// queued when stimulus is applied, then popped one per clock.
`timescale 1ns/1ps
module tb_vip_pattern_gen;

    localparam int BITS    = 8;
    localparam int WIDTH   = 16;
    localparam int W64     = 64;
    localparam int HEIGHT  = 4;
    localparam int H_BLANK = 4;
    localparam int VS      = 1;
    localparam int VB      = 1;
    localparam int VF      = 1;
    localparam int VT      = VS + VB + HEIGHT + VF;

`ifdef VIP_PATGEN_FRAMECNT_EN
    localparam bit FC_EN = 1'b1;
`else
    localparam bit FC_EN = 1'b0;
`endif

    typedef struct packed {
        logic       href;
        logic       vsync;
        logic       done;
        logic [7:0] data;
    } exp_t;

    logic            pclk = 1'b0;
    logic            rst = 1'b1;
    logic            enable = 1'b0;
    logic            enable64 = 1'b0;
    logic [1:0]      mode = 2'd0;
    logic [1:0]      mode64 = 2'd0;

    logic            href0, vsync0, done0;
    logic [BITS-1:0] data0;
    logic            href64, vsync64, done64;
    logic [BITS-1:0] data64;
`ifdef VIP_PATGEN_FRAMECNT_EN
    logic [15:0]     fcnt0, fcnt64;
`endif

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;
    int   frame_no = 0;
    int   frame_errs = 0;

    always #5 pclk = ~pclk;

    vip_pattern_gen #(
        .BITS(BITS), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .H_BLANK(H_BLANK),
        .VSYNC_LINES(VS), .V_BACK(VB), .V_FRONT(VF)
    ) u_dut (
        .pclk(pclk), .rst(rst), .enable(enable), .mode(mode),
        .out_href(href0), .out_vsync(vsync0), .out_data(data0),
        .frame_done(done0)
`ifdef VIP_PATGEN_FRAMECNT_EN
        , .frame_cnt(fcnt0)
`endif
    );

    vip_pattern_gen #(
        .BITS(BITS), .WIDTH(W64), .HEIGHT(HEIGHT), .H_BLANK(H_BLANK),
        .VSYNC_LINES(VS), .V_BACK(VB), .V_FRONT(VF)
    ) u_dut64 (
        .pclk(pclk), .rst(rst), .enable(enable64), .mode(mode64),
        .out_href(href64), .out_vsync(vsync64), .out_data(data64),
        .frame_done(done64)
`ifdef VIP_PATGEN_FRAMECNT_EN
        , .frame_cnt(fcnt64)
`endif
    );

    // Expected output for frame position k (0 = first clock of vsync).
    function automatic exp_t model_pix(input int w, input int k, input int m, input int fc);
        exp_t       e;
        int         ht, h, v, x, y, bar;
        logic [8:0] rep;
        ht = w + H_BLANK;
        h  = k % ht;
        v  = k / ht;
        e  = '0;
        e.vsync = (v < VS);
        e.done  = (k == ht * VT - 1);
        if (v >= VS + VB && v < VS + VB + HEIGHT && h < w) begin
            e.href = 1'b1;
            x = h;
            y = v - (VS + VB);
            case (m)
                0: begin
                    bar = x / (w / 8);
                    if (bar > 7) bar = 7;
                    rep = {3{3'(bar)}};
                    e.data = rep[8:1];
                end
                1: e.data = 8'((x + (FC_EN ? fc : 0)) % 256);
                2: e.data = 8'(y % 256);
                default: e.data = (((x / 32) % 2) != ((y / 32) % 2)) ? 8'hFF : 8'h00;
            endcase
        end
        return e;
    endfunction

    task automatic push_frame(input int w, input int m, input int fc);
        for (int k = 0; k < (w + H_BLANK) * VT; k++) begin
            sb_q.push_back(model_pix(w, k, m, fc));
        end
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) begin
            sb_q.push_back('0);
        end
    endtask

    // One comparison per clock against the head of the scoreboard; an empty
    // scoreboard means all outputs must be 0.
    task automatic check_cycles(input int sel, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            exp_t a;
            @(posedge pclk);
            #1;
            if (sb_q.size() > 0) e = sb_q.pop_front();
            else e = '0;
            if (sel != 0) a = {href64, vsync64, done64, data64};
            else          a = {href0, vsync0, done0, data0};
            checks++;
            if (a !== e) begin
                failures++;
                frame_errs++;
                $display("FAIL %s t=%0t got href=%b vsync=%b done=%b data=%02h expected href=%b vsync=%b done=%b data=%02h",
                         tag, $time, a.href, a.vsync, a.done, a.data,
                         e.href, e.vsync, e.done, e.data);
            end
            if (e.done) begin
                $display("frame %0d (%s) checked, mismatches=%0d", frame_no, tag, frame_errs);
                frame_no++;
                frame_errs = 0;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; enable64 = 1'b0; mode = 2'd0; mode64 = 2'd0;
        for (int i = 0; i < 3; i++) begin
            @(posedge pclk);
            #1;
            checks++;
            if ({href0, vsync0, done0, data0} !== 11'd0) begin
                failures++;
                $display("FAIL reset_dut got %b required 0", {href0, vsync0, done0, data0});
            end
            checks++;
            if ({href64, vsync64, done64, data64} !== 11'd0) begin
                failures++;
                $display("FAIL reset_dut64 got %b required 0", {href64, vsync64, done64, data64});
            end
`ifdef VIP_PATGEN_FRAMECNT_EN
            checks++;
            if (fcnt0 !== 16'd0 || fcnt64 !== 16'd0) begin
                failures++;
                $display("FAIL reset_frame_cnt got %0d/%0d required 0", fcnt0, fcnt64);
            end
`endif
        end
        $display("reset held 3 clocks");
        rst = 1'b0;
    endtask

    task automatic test_hramp();
        enable = 1'b1;
        mode   = 2'd1;
        push_idle(2);
        push_frame(WIDTH, 1, 0);
        push_frame(WIDTH, 1, 1);
        check_cycles(0, 2 + 2 * 140, "hramp");
`ifdef VIP_PATGEN_FRAMECNT_EN
        checks++;
        if (fcnt0 !== 16'd2) begin
            failures++;
            $display("FAIL frame_cnt got %0d required 2", fcnt0);
        end
`endif
    endtask

    // Mode changes one clock after the frame-start latch: the frame already
    // under way keeps the h-ramp, the next one shows bars.
    task automatic test_bars();
        mode = 2'd0;
        push_frame(WIDTH, 1, 2);
        push_frame(WIDTH, 0, 3);
        check_cycles(0, 280, "bars");
    endtask

    task automatic test_mode_switch();
        mode = 2'd1;
        push_frame(WIDTH, 0, 4);
        push_frame(WIDTH, 1, 5);
        check_cycles(0, 140 + 60, "mode_switch");
        mode = 2'd2;
        push_frame(WIDTH, 2, 6);
        check_cycles(0, 80 + 140, "mode_switch");
    endtask

    task automatic test_disable();
        push_frame(WIDTH, 2, 7);
        check_cycles(0, 50, "disable");
        enable = 1'b0;
        check_cycles(0, 90, "disable");
        push_idle(30);
        check_cycles(0, 30, "idle");
        enable = 1'b1;
        push_idle(2);
        push_frame(WIDTH, 2, 8);
        push_idle(20);
        check_cycles(0, 1, "reenable");
        enable = 1'b0;
        check_cycles(0, 161, "reenable");
    endtask

    task automatic test_checker();
        enable64 = 1'b1;
        mode64   = 2'd3;
        push_idle(2);
        push_frame(W64, 3, 0);
        push_idle(5);
        check_cycles(1, 1, "checker");
        enable64 = 1'b0;
        check_cycles(1, 1 + 476 + 5, "checker");
    endtask

    task automatic test_reset_mid();
        enable = 1'b1;
        mode   = 2'd1;
        push_idle(2);
        push_frame(WIDTH, 1, 9);
        check_cycles(0, 47, "reset_mid");
        sb_q.delete();
        rst = 1'b1;
        push_idle(1);
        check_cycles(0, 1, "reset_mid");
        rst = 1'b0;
        push_idle(2);
        push_frame(WIDTH, 1, 0);
        check_cycles(0, 142, "restart");
    endtask

    initial begin
        test_reset();
        test_hramp();
        test_bars();
        test_mode_switch();
        test_disable();
        test_checker();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
